// File: rtl/mult_acc_unit.sv
// Multiply-accumulate stage: sums N_SAMPLES signed 32-bit products into a signed
// ACC_W accumulator and presents each finished sum on a valid/ready port.
module mult_acc_unit #(
  parameter int ACC_W     = 40,
  parameter int N_SAMPLES = 16,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [31:0]      C_NUM,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic                    acc_clr,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    acc_ovf
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             acc_valid_q, acc_valid_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic [ACC_W:0]   sum_ext_s;
  logic             ovf_s;
  logic [ACC_W-1:0] sum_sel_s;
  logic             accept_s;
  logic             last_s;

  // One extra bit of headroom makes signed overflow a disagreement of the top two bits.
  assign sum_ext_s = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-31){C_NUM[31]}}, C_NUM};
  assign ovf_s     = sum_ext_s[ACC_W] ^ sum_ext_s[ACC_W-1];
  assign accept_s  = prod_valid & prod_ready;
  assign last_s    = (cnt_q == CNT_W'(N_SAMPLES - 1));

  assign prod_ready = (state_q == ST_ACCUM) & ~acc_clr;
  assign acc_out    = acc_out_q;
  assign acc_valid  = acc_valid_q;
  assign acc_ovf    = acc_ovf_q;

  // Saturate or wrap the candidate sum.
  always_comb begin
    sum_sel_s = sum_ext_s[ACC_W-1:0];
    if (ovf_s && (SAT_EN == 1'b1)) begin
      if (sum_ext_s[ACC_W]) begin
        sum_sel_s = ACC_MIN;
      end else begin
        sum_sel_s = ACC_MAX;
      end
    end else begin
      sum_sel_s = sum_ext_s[ACC_W-1:0];
    end
  end

  // Next-state logic for accumulation and result hand-off.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    acc_out_d    = acc_out_q;
    acc_valid_d  = acc_valid_q;
    acc_ovf_d    = acc_ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (acc_clr) begin
          acc_d        = {ACC_W{1'b0}};
          cnt_d        = {CNT_W{1'b0}};
          ovf_sticky_d = 1'b0;
        end else if (accept_s) begin
          if (last_s) begin
            acc_out_d    = sum_sel_s;
            acc_ovf_d    = ovf_sticky_q | ovf_s;
            acc_valid_d  = 1'b1;
            state_d      = ST_HOLD;
            acc_d        = {ACC_W{1'b0}};
            cnt_d        = {CNT_W{1'b0}};
            ovf_sticky_d = 1'b0;
          end else begin
            acc_d        = sum_sel_s;
            cnt_d        = cnt_q + CNT_W'(1);
            ovf_sticky_d = ovf_sticky_q | ovf_s;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        // acc_clr is deliberately ignored here: a finished result is only released by acc_ready.
        if (acc_ready) begin
          acc_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d      = ST_ACCUM;
        acc_d        = {ACC_W{1'b0}};
        cnt_d        = {CNT_W{1'b0}};
        ovf_sticky_d = 1'b0;
        acc_valid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      acc_q        <= {ACC_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      ovf_sticky_q <= 1'b0;
      acc_out_q    <= {ACC_W{1'b0}};
      acc_valid_q  <= 1'b0;
      acc_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      acc_out_q    <= acc_out_d;
      acc_valid_q  <= acc_valid_d;
      acc_ovf_q    <= acc_ovf_d;
    end
  end

endmodule

// File: tb/tb_mult_acc_unit.sv
// Directed and randomized self-checking bench for mult_acc_unit.
module tb_mult_acc_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance: ACC_W=40, N_SAMPLES=4, saturating.
  logic [31:0] c_num;
  logic        pv, pr, clr, av, ar, ovf;
  logic [39:0] ao;

  // Narrow instances for overflow corners, sharing one stimulus.
  logic [31:0] c3;
  logic        pv3, ar3;
  logic        pr_s, av_s, ovf_s, pr_w, av_w, ovf_w;
  logic [33:0] ao_s, ao_w;

  // Single-sample instance.
  logic [31:0] c1;
  logic        pv1, ar1, pr1, av1, ovf1;
  logic [32:0] ao1;

  mult_acc_unit #(.ACC_W(40), .N_SAMPLES(4), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .C_NUM(c_num), .prod_valid(pv), .prod_ready(pr),
    .acc_clr(clr), .acc_out(ao), .acc_valid(av), .acc_ready(ar), .acc_ovf(ovf));

  mult_acc_unit #(.ACC_W(34), .N_SAMPLES(8), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .C_NUM(c3), .prod_valid(pv3), .prod_ready(pr_s),
    .acc_clr(1'b0), .acc_out(ao_s), .acc_valid(av_s), .acc_ready(ar3), .acc_ovf(ovf_s));

  mult_acc_unit #(.ACC_W(34), .N_SAMPLES(8), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .C_NUM(c3), .prod_valid(pv3), .prod_ready(pr_w),
    .acc_clr(1'b0), .acc_out(ao_w), .acc_valid(av_w), .acc_ready(ar3), .acc_ovf(ovf_w));

  mult_acc_unit #(.ACC_W(33), .N_SAMPLES(1), .SAT_EN(1'b1)) dut_one (
    .clk(clk), .rst(rst), .C_NUM(c1), .prod_valid(pv1), .prod_ready(pr1),
    .acc_clr(1'b0), .acc_out(ao1), .acc_valid(av1), .acc_ready(ar1), .acc_ovf(ovf1));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] v);
    c_num = v;
    pv    = 1'b1;
    tick();
  endtask

  task automatic feed3(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      c3  = v;
      pv3 = 1'b1;
      tick();
    end
    pv3 = 1'b0;
  endtask

  // Random-phase model state.
  longint m_sum, m_res, s;
  int     m_cnt;
  logic   m_hold, m_ovf, m_res_ovf;
  shortint op_a, op_b;
  int     prod;
  localparam longint LIM_MAX = 64'sd549755813887;   // 2^39-1
  localparam longint LIM_MIN = -64'sd549755813888;  // -2^39

  initial begin
    rst = 1'b1; c_num = 32'd0; pv = 1'b0; clr = 1'b0; ar = 1'b1;
    c3 = 32'd0; pv3 = 1'b0; ar3 = 1'b1;
    c1 = 32'd0; pv1 = 1'b0; ar1 = 1'b1;
    tick(); tick();
    check_eq("rst_out",   64'(ao),  64'd0);
    check_eq("rst_valid", 64'(av),  64'd0);
    check_eq("rst_ovf",   64'(ovf), 64'd0);
    check_eq("rst_ready", 64'(pr),  64'd1);
    rst = 1'b0;
    tick();

    // T1: 100 - 50 + 25 - 1 = 74, valid for a single cycle.
    feed(32'd100); feed(-32'sd50); feed(32'd25); feed(-32'sd1);
    pv = 1'b0;
    check_eq("t1_valid", 64'(av),  64'd1);
    check_eq("t1_out",   64'(ao),  64'd74);
    check_eq("t1_ovf",   64'(ovf), 64'd0);
    check_eq("t1_ready", 64'(pr),  64'd0);
    tick();
    check_eq("t1_valid_drop", 64'(av), 64'd0);
    check_eq("t1_ready_back", 64'(pr), 64'd1);

    // T2: backpressure holds the result; extra products are refused.
    ar = 1'b0;
    feed(32'd100); feed(-32'sd50); feed(32'd25); feed(-32'sd1);
    c_num = 32'd12345;
    pv    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("t2_valid", 64'(av), 64'd1);
      check_eq("t2_out",   64'(ao), 64'd74);
      check_eq("t2_ready", 64'(pr), 64'd0);
      tick();
    end
    pv = 1'b0;
    ar = 1'b1;
    tick();
    check_eq("t2_release_valid", 64'(av), 64'd0);
    check_eq("t2_release_ready", 64'(pr), 64'd1);
    feed(32'd1); feed(32'd1); feed(32'd1); feed(32'd1);
    pv = 1'b0;
    check_eq("t2_no_leak", 64'(ao), 64'd4);
    tick();

    // T4: acc_clr wins over prod_valid and drops the partial sum.
    feed(32'd7); feed(32'd7);
    clr   = 1'b1;
    c_num = 32'd99;
    pv    = 1'b1;
    #0;
    check_eq("t4_clr_ready", 64'(pr), 64'd0);
    tick();
    clr = 1'b0;
    feed(32'd1); feed(32'd2); feed(32'd3); feed(32'd4);
    pv = 1'b0;
    check_eq("t4_valid", 64'(av), 64'd1);
    check_eq("t4_out",   64'(ao), 64'd10);
    tick();

    // T5: async reset mid-block and while holding a result.
    feed(32'd5); feed(32'd5);
    pv = 1'b0;
    check_eq("t5_prev_out", 64'(ao), 64'd10);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst_out",   64'(ao), 64'd0);
    check_eq("t5_rst_valid", 64'(av), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    ar = 1'b0;
    feed(32'd5); feed(32'd5); feed(32'd5); feed(32'd5);
    pv = 1'b0;
    check_eq("t5_hold_valid", 64'(av), 64'd1);
    check_eq("t5_hold_out",   64'(ao), 64'd20);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst2_out",   64'(ao), 64'd0);
    check_eq("t5_rst2_valid", 64'(av), 64'd0);
    check_eq("t5_rst2_ready", 64'(pr), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    ar = 1'b1;
    feed(32'd5); feed(32'd5); feed(32'd5); feed(32'd5);
    pv = 1'b0;
    check_eq("t5_out", 64'(ao), 64'd20);
    tick();

    // T3: eight 2^30 overflow a 34-bit accumulator by one LSB.
    feed3(32'h4000_0000, 8);
    check_eq("t3_sat_out",  64'(ao_s),  64'h1_FFFF_FFFF);
    check_eq("t3_sat_ovf",  64'(ovf_s), 64'd1);
    check_eq("t3_wrap_out", 64'(ao_w),  64'h2_0000_0000);
    check_eq("t3_wrap_ovf", 64'(ovf_w), 64'd1);
    tick();
    feed3(32'd1, 8);
    check_eq("t3_clean_out", 64'(ao_s),  64'd8);
    check_eq("t3_clean_ovf", 64'(ovf_s), 64'd0);
    check_eq("t3_clean_wovf", 64'(ovf_w), 64'd0);
    tick();
    // Exactly the most negative value: no overflow.
    feed3(32'hC000_0000, 8);
    check_eq("t3_min_out",  64'(ao_s),  64'h2_0000_0000);
    check_eq("t3_min_ovf",  64'(ovf_s), 64'd0);
    check_eq("t3_min_wout", 64'(ao_w),  64'h2_0000_0000);
    tick();
    // Eight -2^31: clamps at min, wraps to zero.
    feed3(32'h8000_0000, 8);
    check_eq("t3_neg_sat_out",  64'(ao_s),  64'h2_0000_0000);
    check_eq("t3_neg_sat_ovf",  64'(ovf_s), 64'd1);
    check_eq("t3_neg_wrap_out", 64'(ao_w),  64'd0);
    check_eq("t3_neg_wrap_ovf", 64'(ovf_w), 64'd1);
    tick();

    // N_SAMPLES=1: every product is a result.
    ar1 = 1'b0;
    c1 = -32'sd5; pv1 = 1'b1;
    tick();
    pv1 = 1'b0;
    check_eq("n1_out",   64'(ao1), 64'h1_FFFF_FFFB);
    check_eq("n1_valid", 64'(av1), 64'd1);
    check_eq("n1_ready", 64'(pr1), 64'd0);
    ar1 = 1'b1;
    tick();
    check_eq("n1_drop", 64'(av1), 64'd0);
    c1 = 32'h7FFF_FFFF; pv1 = 1'b1;
    tick();
    pv1 = 1'b0;
    check_eq("n1_out2", 64'(ao1), 64'h0_7FFF_FFFF);
    check_eq("n1_ovf2", 64'(ovf1), 64'd0);

    // T6: random 16x16 products with random handshakes against a model.
    rst = 1'b1; tick(); rst = 1'b0;
    m_sum = 0; m_cnt = 0; m_hold = 1'b0; m_ovf = 1'b0; m_res = 0; m_res_ovf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      check_eq("rnd_valid", 64'(av), 64'(m_hold));
      if (m_hold) begin
        check_eq("rnd_out", 64'(ao), 64'(m_res[39:0]));
        check_eq("rnd_ovf", 64'(ovf), 64'(m_res_ovf));
      end else begin
        m_ovf = m_ovf;
      end
      op_a  = shortint'($urandom);
      op_b  = shortint'($urandom);
      prod  = int'(op_a) * int'(op_b);
      c_num = prod;
      pv    = ($urandom_range(0, 3) != 0);
      ar    = ($urandom_range(0, 2) != 0);
      check_eq("rnd_ready", 64'(pr), 64'(!m_hold));
      if (m_hold) begin
        if (ar) m_hold = 1'b0;
      end else if (pv) begin
        s = m_sum + longint'(prod);
        if (s > LIM_MAX) begin
          s = LIM_MAX; m_ovf = 1'b1;
        end else if (s < LIM_MIN) begin
          s = LIM_MIN; m_ovf = 1'b1;
        end
        m_sum = s;
        m_cnt++;
        if (m_cnt == 4) begin
          m_res = m_sum; m_res_ovf = m_ovf; m_hold = 1'b1;
          m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
        end
      end
      tick();
    end
    pv = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
